battleship_game_ctrl: RTL and testbench

Sequential scorekeeper directly downstream of the shot-evaluation stage (hit / near-miss / miss classification and shot validity check).
- Per accepted shot, consumes the combinational Hit/nearMiss/Miss/SomethingIsWrong results.
- Holds the registered game state: TotalHits, BigLeft, shot count and win/loss.
- TotalHits and BigLeft feed back to the evaluation stage.
- A shot-history bitmap rejects repeated coordinates.

---
 rtl/battleship_pkg.sv | 30 +++
 rtl/battleship_game_ctrl_shot_history.sv | 49 ++++
 rtl/battleship_game_ctrl.sv | 148 ++++++++++++++
 tb/tb_battleship_game_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// -----------------------------------------------------------------------------
// battleship_pkg
// Shared types and constants for the battleship scorekeeper slice.
//   game_state_t : IDLE / PLAY / WON / LOST
//   GRID_DIM     : board edge length (coordinates are 1..GRID_DIM)
//   SHIP_SQUARES : occupied squares; hitting all of them wins the game
//   BIG_INIT     : big bombs available at game start (2'b11 is not a legal count)
//   MAX_SHOTS    : accepted-shot limit before the game is lost
//   sat_inc()    : 7-bit increment that sticks at 127
// -----------------------------------------------------------------------------
package battleship_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } game_state_t;

  localparam int GRID_DIM     = 10;
  localparam int SHIP_SQUARES = 19;
  localparam int BIG_INIT     = 2;
  localparam int MAX_SHOTS    = 40;

  // Counters are 7 bits wide and must never wrap back to zero.
  function automatic logic [6:0] sat_inc(input logic [6:0] value, input logic en);
    return (en && (value != 7'h7F)) ? value + 7'd1 : value;
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_shot_history.sv
// -----------------------------------------------------------------------------
// shot_history
// 100-bit bitmap recording which grid squares have already been fired at.
// Ports:
//   clock    : system clock
//   reset_L  : synchronous active-low reset, clears the whole bitmap
//   clear    : synchronous clear at the start of a new game
//   set      : mark square (X,Y) as used on this edge
//   X, Y     : shot coordinate, legal range 1..GRID_DIM
//   seen     : combinational; square (X,Y) already marked
// Out-of-range coordinates never read as seen and are never written, so a
// stray X=0 or Y=15 cannot alias onto a real square.
// -----------------------------------------------------------------------------
module shot_history
  import battleship_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       clear,
  input  logic       set,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic       seen
);

  localparam int         CELLS = GRID_DIM * GRID_DIM;
  localparam logic [3:0] DIM4  = 4'(GRID_DIM);
  localparam logic [6:0] DIM7  = 7'(GRID_DIM);

  logic [CELLS-1:0] bitmap;
  logic             in_range;
  logic [6:0]       idx;

  assign in_range = (X >= 4'd1) && (X <= DIM4) && (Y >= 4'd1) && (Y <= DIM4);
  // Row-major: (Y-1)*10 + (X-1). Only meaningful when in_range.
  assign idx      = 7'(Y - 4'd1) * DIM7 + 7'(X - 4'd1);
  assign seen     = in_range && bitmap[idx];

  // NOTE: this "memory" is a bank of flops that must start every game empty,
  // so unlike a RAM it is reset and cleared explicitly.
  always_ff @(posedge clock) begin
    if (!reset_L || clear) begin
      bitmap <= '0;
    end else if (set && in_range) begin
      bitmap[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/battleship_game_ctrl.sv
// -----------------------------------------------------------------------------
// battleship_game_ctrl
// Registered scorekeeper downstream of the shot-evaluation stage. Per accepted
// shot it accumulates hits, shot count and big-bomb usage, and decides
// win/loss. TotalHits and BigLeft feed back to the evaluation stage.
//
// Optional build macro: NEAR_MISS_COUNT_EN adds the NearMisses output.
//
// Ports:
//   clock, reset_L       : clock, synchronous active-low reset
//   StartGame            : pulse, (re)starts a game from IDLE/WON/LOST
//   ScoreThis            : shot strobe, honoured only while Ready
//   X, Y, Big            : shot coordinate (1..10) and big-bomb flag
//   Hit, nearMiss, Miss  : evaluation results for this shot
//   SomethingIsWrong     : upstream validity failure, rejects the shot
//   Ready                : high in PLAY
//   TotalHits, BigLeft   : registered hit count / big bombs remaining
//   ShotsTaken           : accepted shots
//   ShotError/RepeatShot : one-cycle pulses on rejected / repeated shots
//   NearMisses           : (optional) accepted near-miss count
//   GameWon, GameOver    : game result levels
// -----------------------------------------------------------------------------
module battleship_game_ctrl #(
  parameter int MAX_SHOTS    = battleship_pkg::MAX_SHOTS,
  parameter int SHIP_SQUARES = battleship_pkg::SHIP_SQUARES,
  parameter int BIG_INIT     = battleship_pkg::BIG_INIT
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       StartGame,
  input  logic       ScoreThis,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Big,
  input  logic       Hit,
  input  logic       nearMiss,
  input  logic       Miss,
  input  logic       SomethingIsWrong,
  output logic       Ready,
  output logic [6:0] TotalHits,
  output logic [1:0] BigLeft,
  output logic [6:0] ShotsTaken,
  output logic       ShotError,
  output logic       RepeatShot,
  output logic       GameWon,
`ifdef NEAR_MISS_COUNT_EN
  output logic [6:0] NearMisses,
`endif
  output logic       GameOver
);

  import battleship_pkg::*;

  localparam logic [6:0] WIN_HITS   = 7'(SHIP_SQUARES);
  localparam logic [6:0] SHOT_LIMIT = 7'(MAX_SHOTS);
  localparam logic [1:0] BIG_START  = 2'(BIG_INIT);

  game_state_t state;
  logic        seen;
  logic        shot_valid;
  logic        accept;
  logic        start;
  logic [6:0]  hits_next;
  logic [6:0]  shots_next;
  logic [1:0]  big_next;

  assign Ready    = (state == PLAY);
  assign GameWon  = (state == WON);
  assign GameOver = (state == WON) || (state == LOST);

  assign shot_valid = ScoreThis && Ready;
  // Priority: upstream error, then repeat, then accept.
  assign accept     = shot_valid && !SomethingIsWrong && !seen;
  // Start is only honoured outside PLAY; in WON/LOST Ready is low, so a
  // coincident shot is dropped automatically.
  assign start      = StartGame && (state != PLAY);

  assign hits_next  = sat_inc(TotalHits, Hit);
  assign shots_next = sat_inc(ShotsTaken, 1'b1);
  // Upstream already rejects Big with no bombs left; saturate anyway.
  assign big_next   = (Big && (BigLeft != 2'd0)) ? BigLeft - 2'd1 : BigLeft;

  shot_history u_history (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (start),
    .set     (accept),
    .X       (X),
    .Y       (Y),
    .seen    (seen)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state      <= IDLE;
      TotalHits  <= '0;
      BigLeft    <= '0;
      ShotsTaken <= '0;
      ShotError  <= 1'b0;
      RepeatShot <= 1'b0;
    end else begin
      ShotError  <= 1'b0;
      RepeatShot <= 1'b0;
      if (start) begin
        state      <= PLAY;
        TotalHits  <= '0;
        ShotsTaken <= '0;
        BigLeft    <= BIG_START;
      end else if (shot_valid) begin
        if (SomethingIsWrong) begin
          ShotError <= 1'b1;
        end else if (seen) begin
          RepeatShot <= 1'b1;
        end else begin
          TotalHits  <= hits_next;
          ShotsTaken <= shots_next;
          BigLeft    <= big_next;
          // Win is checked first so a last-shot win is never scored as a loss.
          if (hits_next == WIN_HITS) begin
            state <= WON;
          end else if (shots_next == SHOT_LIMIT) begin
            state <= LOST;
          end
        end
      end
    end
  end

`ifdef NEAR_MISS_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset_L || start) begin
      NearMisses <= '0;
    end else if (accept) begin
      NearMisses <= sat_inc(NearMisses, nearMiss);
    end
  end

  logic unused_inputs;
  assign unused_inputs = Miss;
`else
  // Miss is implied by !Hit && !nearMiss; nearMiss only feeds the optional counter.
  logic unused_inputs;
  assign unused_inputs = ^{Miss, nearMiss};
`endif

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_battleship_game_ctrl
// Directed, table-driven bench for battleship_game_ctrl plus hand-written
// sequences for win, loss, win-on-last-shot, restart and mid-game reset.
// -----------------------------------------------------------------------------
module tb_battleship_game_ctrl;

  logic       clock;
  logic       reset_L;
  logic       StartGame, ScoreThis;
  logic [3:0] X, Y;
  logic       Big, Hit, nearMiss, Miss, SomethingIsWrong;
  logic       Ready;
  logic [6:0] TotalHits;
  logic [1:0] BigLeft;
  logic [6:0] ShotsTaken;
  logic       ShotError, RepeatShot, GameWon, GameOver;
  logic [6:0] NearMisses;

  int checks = 0;
  int errors = 0;

  battleship_game_ctrl dut (
    .clock            (clock),
    .reset_L          (reset_L),
    .StartGame        (StartGame),
    .ScoreThis        (ScoreThis),
    .X                (X),
    .Y                (Y),
    .Big              (Big),
    .Hit              (Hit),
    .nearMiss         (nearMiss),
    .Miss             (Miss),
    .SomethingIsWrong (SomethingIsWrong),
    .Ready            (Ready),
    .TotalHits        (TotalHits),
    .BigLeft          (BigLeft),
    .ShotsTaken       (ShotsTaken),
    .ShotError        (ShotError),
    .RepeatShot       (RepeatShot),
    .GameWon          (GameWon),
`ifdef NEAR_MISS_COUNT_EN
    .NearMisses       (NearMisses),
`endif
    .GameOver         (GameOver)
  );

`ifndef NEAR_MISS_COUNT_EN
  assign NearMisses = '0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start, score;
    logic [3:0] x, y;
    logic       big, hit, nm, sw;
    logic [20:0] exp;  // {ready, hits, bigleft, shots, err, rep, won, over}
  } vec_t;

  vec_t vecs[13];

  function automatic logic [20:0] pack(input logic rdy, input logic [6:0] h,
                                       input logic [1:0] b, input logic [6:0] s,
                                       input logic e, input logic r,
                                       input logic w, input logic o);
    return {rdy, h, b, s, e, r, w, o};
  endfunction

  function automatic vec_t mk(input logic st, input logic sc, input int x, input int y,
                              input logic bg, input logic h, input logic nm,
                              input logic sw, input logic [20:0] e);
    vec_t v;
    v.start = st; v.score = sc; v.x = 4'(x); v.y = 4'(y);
    v.big = bg; v.hit = h; v.nm = nm; v.sw = sw; v.exp = e;
    return v;
  endfunction

  function automatic logic [20:0] observed();
    return {Ready, TotalHits, BigLeft, ShotsTaken, ShotError, RepeatShot, GameWon, GameOver};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; outputs are valid #1 after the sampling edge.
  task automatic drive(input logic st, input logic sc, input logic [3:0] x, input logic [3:0] y,
                       input logic bg, input logic h, input logic nm, input logic sw);
    @(negedge clock);
    StartGame = st; ScoreThis = sc; X = x; Y = y;
    Big = bg; Hit = h; nearMiss = nm; SomethingIsWrong = sw;
    Miss = sc && !h && !nm;
    @(posedge clock);
    #1;
    StartGame = 1'b0; ScoreThis = 1'b0;
  endtask

  task automatic shot(input int x, input int y, input logic h);
    drive(1'b0, 1'b1, 4'(x), 4'(y), 1'b0, h, 1'b0, 1'b0);
  endtask

  task automatic start_game();
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_L = 1'b0; StartGame = 1'b0; ScoreThis = 1'b0; X = '0; Y = '0;
    Big = 1'b0; Hit = 1'b0; nearMiss = 1'b0; Miss = 1'b0; SomethingIsWrong = 1'b0;

    //                 st  sc  x  y  big hit nm sw   rdy hits bl shots err rep won over
    vecs[0]  = mk(1'b0,1'b1,2,2,1'b0,1'b1,1'b0,1'b0, pack(0, 0, 0, 0, 0, 0, 0, 0)); // shot in IDLE ignored
    vecs[1]  = mk(1'b1,1'b0,0,0,1'b0,1'b0,1'b0,1'b0, pack(1, 0, 2, 0, 0, 0, 0, 0)); // start
    vecs[2]  = mk(1'b1,1'b0,0,0,1'b0,1'b0,1'b0,1'b0, pack(1, 0, 2, 0, 0, 0, 0, 0)); // start in PLAY ignored
    vecs[3]  = mk(1'b0,1'b1,2,2,1'b0,1'b1,1'b0,1'b0, pack(1, 1, 2, 1, 0, 0, 0, 0)); // hit (2,2)
    vecs[4]  = mk(1'b0,1'b1,2,2,1'b0,1'b1,1'b0,1'b0, pack(1, 1, 2, 1, 0, 1, 0, 0)); // repeat (2,2)
    vecs[5]  = mk(1'b0,1'b0,0,0,1'b0,1'b0,1'b0,1'b0, pack(1, 1, 2, 1, 0, 0, 0, 0)); // pulse ends
    vecs[6]  = mk(1'b0,1'b1,0,0,1'b0,1'b0,1'b0,1'b1, pack(1, 1, 2, 1, 1, 0, 0, 0)); // X=0 flagged
    vecs[7]  = mk(1'b0,1'b1,1,1,1'b1,1'b0,1'b0,1'b0, pack(1, 1, 1, 2, 0, 0, 0, 0)); // big (1,1)
    vecs[8]  = mk(1'b0,1'b1,1,3,1'b1,1'b0,1'b0,1'b0, pack(1, 1, 0, 3, 0, 0, 0, 0)); // big (1,3)
    vecs[9]  = mk(1'b0,1'b1,1,4,1'b1,1'b0,1'b0,1'b1, pack(1, 1, 0, 3, 1, 0, 0, 0)); // big, none left
    vecs[10] = mk(1'b0,1'b1,1,4,1'b0,1'b0,1'b0,1'b0, pack(1, 1, 0, 4, 0, 0, 0, 0)); // (1,4) never marked
    vecs[11] = mk(1'b0,1'b1,1,1,1'b0,1'b0,1'b0,1'b0, pack(1, 1, 0, 4, 0, 1, 0, 0)); // repeat (1,1)
    vecs[12] = mk(1'b0,1'b1,3,3,1'b0,1'b0,1'b1,1'b0, pack(1, 1, 0, 5, 0, 0, 0, 0)); // near miss

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clock);
    reset_L = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].score, vecs[i].x, vecs[i].y,
            vecs[i].big, vecs[i].hit, vecs[i].nm, vecs[i].sw);
      check($sformatf("vec%0d", i), 32'(observed()), 32'(vecs[i].exp));
    end
`ifdef NEAR_MISS_COUNT_EN
    check("near_misses", 32'(NearMisses), 32'd1);
`endif

    // Win: 18 more hits on rows 5 and 6 (hits 1 -> 19, shots 5 -> 23).
    for (int i = 0; i < 18; i++) begin
      shot(i % 10 + 1, 5 + i / 10, 1'b1);
      if (i == 16) check("pre_win", 32'({Ready, GameWon, TotalHits}), 32'({1'b1, 1'b0, 7'd18}));
    end
    check("win", 32'(observed()), 32'(pack(0, 19, 0, 23, 0, 0, 1, 1)));
    shot(7, 7, 1'b1);
    check("shot_in_won", 32'(observed()), 32'(pack(0, 19, 0, 23, 0, 0, 1, 1)));
    // Start coincident with a shot: start wins, shot dropped.
    drive(1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    check("start_with_shot", 32'(observed()), 32'(pack(1, 0, 2, 0, 0, 0, 0, 0)));

    // 21 misses then 19 hits: the 19th hit is also shot 40 -> WON, not LOST.
    for (int i = 0; i < 40; i++) begin
      shot(i % 10 + 1, i / 10 + 1, (i >= 21));
      if (i == 38) check("pre_win40", 32'(observed()), 32'(pack(1, 18, 2, 39, 0, 0, 0, 0)));
    end
    check("win_on_40", 32'(observed()), 32'(pack(0, 19, 2, 40, 0, 0, 1, 1)));

    // 40 misses -> LOST.
    start_game();
    for (int i = 0; i < 40; i++) begin
      shot(i % 10 + 1, i / 10 + 1, 1'b0);
      if (i == 38) check("pre_lost", 32'(observed()), 32'(pack(1, 0, 2, 39, 0, 0, 0, 0)));
    end
    check("lost", 32'(observed()), 32'(pack(0, 0, 2, 40, 0, 0, 0, 1)));

    // Restart from LOST: counters cleared and history empty.
    start_game();
    check("restart", 32'(observed()), 32'(pack(1, 0, 2, 0, 0, 0, 0, 0)));
    shot(1, 1, 1'b0);
    check("bitmap_cleared", 32'(observed()), 32'(pack(1, 0, 2, 1, 0, 0, 0, 0)));
    shot(2, 1, 1'b1);
    check("hit_after_restart", 32'(observed()), 32'(pack(1, 1, 2, 2, 0, 0, 0, 0)));

    // Mid-game reset aborts to IDLE.
    @(negedge clock);
    reset_L = 1'b0;
    @(posedge clock);
    #1;
    check("midgame_reset", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clock);
    reset_L = 1'b1;
    shot(3, 1, 1'b1);
    check("idle_after_reset", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
